// File: rtl/regdump_pkg.sv
// Shared definitions for the register-file dump reader.
// REGDUMP_SKIP_ZERO_EN: when defined, dumps start at index 1 so the hard-wired zero register is skipped.
package regdump_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int NUM_REGS_DEF = 32;
  localparam int IDX_W        = $clog2(NUM_REGS_DEF);

`ifdef REGDUMP_SKIP_ZERO_EN
  localparam int FIRST_IDX = 1;
`else
  localparam int FIRST_IDX = 0;
`endif

endpackage

// File: rtl/regdump_idx_counter.sv
// Register index walker: loads the first index, increments on request,
// and saturates at the final register so it can never wrap.
module regdump_idx_counter
  import regdump_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int IDX_W    = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             inc,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0] LOAD_IDX = IDX_W'(FIRST_IDX);

  assign last = (idx == LAST_IDX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx <= '0;
    end else if (load) begin
      idx <= LOAD_IDX;
    end else if (inc && !last) begin
      idx <= idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/regfile_dump_reader.sv
// Walks a register file through a combinational read port and streams each
// value out over a valid/ready handshake. First index selected by REGDUMP_SKIP_ZERO_EN.
module regfile_dump_reader
  import regdump_pkg::*;
#(
  parameter int N        = 32,
  parameter int NUM_REGS = NUM_REGS_DEF,
  localparam int IDX_W   = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [IDX_W-1:0] rd_addr,
  input  logic [N-1:0]     rd_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             idx_last;
  logic             idx_load;
  logic             idx_inc;

  // Start is only honoured in IDLE, so requests while busy or in DONE fall away.
  assign idx_load = (state == IDLE) && start;
  assign idx_inc  = (state == SEND) && out_ready;

  regdump_idx_counter #(
    .NUM_REGS (NUM_REGS),
    .IDX_W    (IDX_W)
  ) u_idx (
    .clk   (clk),
    .reset (reset),
    .load  (idx_load),
    .inc   (idx_inc),
    .idx   (idx),
    .last  (idx_last)
  );

  assign rd_addr = (state == FETCH) ? idx : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= FETCH;
            busy  <= 1'b1;
          end
        end
        FETCH: begin
          out_data  <= rd_data;
          out_idx   <= idx;
          out_last  <= idx_last;
          out_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          // Word and flags stay frozen until the consumer takes them.
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (idx_last) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= FETCH;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomized self-checking bench for regfile_dump_reader against a queue-based
// model of the expected word stream.
module tb_regfile_dump_reader;

  localparam int N  = 32;
  localparam int NR = 32;
  localparam int IW = 5;
`ifdef REGDUMP_SKIP_ZERO_EN
  localparam int FIRST = 1;
`else
  localparam int FIRST = 0;
`endif
  localparam int WORDS = NR - FIRST;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          out_ready = 1'b0;
  logic [IW-1:0] rd_addr;
  logic [N-1:0]  rd_data;
  logic          out_valid;
  logic [N-1:0]  out_data;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          busy;
  logic          done;

  logic [N-1:0] regs [NR];
  assign rd_data = regs[rd_addr];

  regfile_dump_reader #(.N(N), .NUM_REGS(NR)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [IW-1:0] idx;
    logic [N-1:0]  data;
    logic          last;
  } word_t;
  word_t expq[$];

  task automatic load_expect();
    word_t w;
    for (int i = FIRST; i < NR; i++) begin
      w.idx  = IW'(i);
      w.data = regs[i];
      w.last = (i == NR - 1);
      expq.push_back(w);
    end
  endtask

  // Consumer: 0 = always ready, 1 = stall 5 cycles on word 3, 2 = random.
  int rmode = 0;
  int stall_cnt = 0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: out_ready = 1'b1;
        1: begin
          if (out_valid && out_idx == 3 && stall_cnt < 5) begin
            out_ready = 1'b0;
            stall_cnt++;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Stream monitor.
  bit            mon_en = 1'b0;
  int            cyc = 0;
  int            last_xfer_cyc = -10;
  int            done_cnt = 0;
  int            xfer_cnt = 0;
  logic          pv = 1'b0, pr = 1'b0, pl = 1'b0;
  logic [N-1:0]  pd = '0;
  logic [IW-1:0] pi = '0;

  always @(negedge clk) begin
    word_t w;
    cyc++;
    if (mon_en) begin
      if (pv && !pr) begin
        check("valid_held", out_valid, 1);
        if (out_valid) begin
          check("data_stable", out_data, pd);
          check("idx_stable", out_idx, pi);
          check("last_stable", out_last, pl);
        end
      end
      if (out_valid) check("rd_addr_in_send", rd_addr, 0);
      check("last_without_valid", out_last && !out_valid, 0);
      if (out_valid && out_ready) begin
        xfer_cnt++;
        if (expq.size() == 0) begin
          check("unexpected_word", out_valid, 0);
        end else begin
          w = expq.pop_front();
          check("word_idx", out_idx, w.idx);
          check("word_data", out_data, w.data);
          check("word_last", out_last, w.last);
          last_xfer_cyc = cyc;
        end
      end
      if (done) begin
        done_cnt++;
        check("done_after_last", cyc, last_xfer_cyc + 1);
        check("done_all_words", expq.size(), 0);
      end
    end
    pv = out_valid;
    pr = out_ready;
    pd = out_data;
    pi = out_idx;
    pl = out_last;
  end

  task automatic run_dump(input bit timing, input int restart_at);
    int n;
    int d0;
    int x0;
    bit fired;
    d0 = done_cnt;
    x0 = xfer_cnt;
    fired = 1'b0;
    load_expect();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_after_start", busy, 1);
    n = 0;
    while (!out_valid && n < 8) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (timing) check("start_to_valid_edges", n + 1, 2);
    while (!done && n < 3000) begin
      start = 1'b0;
      if (restart_at >= 0 && !fired && out_valid && out_idx == IW'(restart_at)) begin
        start = 1'b1;
        fired = 1'b1;
      end
      @(posedge clk);
      #1;
      n++;
    end
    start = 1'b0;
    check("done_seen", done, 1);
    if (timing) check("dump_cycles", n, 2 * WORDS);
    @(posedge clk);
    #1;
    check("done_one_cycle", done, 0);
    check("busy_cleared", busy, 0);
    check("one_done_pulse", done_cnt - d0, 1);
    check("word_count", xfer_cnt - x0, WORDS);
    if (restart_at >= 0) begin
      check("restart_fired", fired, 1);
      for (int k = 0; k < 4; k++) begin
        @(posedge clk);
        #1;
        check("no_queued_dump", busy | out_valid, 0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int d0;
    for (int i = 0; i < NR; i++) regs[i] = 32'h1000_0000 + i;
`ifdef REGDUMP_SKIP_ZERO_EN
    regs[0] = '0;
`endif
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    @(negedge clk);
    reset = 1'b1;
    #1 mon_en = 1'b1;

    rmode = 0;
    run_dump(1'b1, -1);

    stall_cnt = 0;
    rmode = 1;
    run_dump(1'b0, -1);
    check("stall_cycles", stall_cnt, 5);

    rmode = 0;
    run_dump(1'b1, 10);

    // Asynchronous reset in the middle of a dump.
    load_expect();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (!(out_valid && out_idx == 7) && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reached_idx7", out_valid && out_idx == 7, 1);
    #2;
    mon_en = 1'b0;
    reset = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_idx", out_idx, 0);
    check("async_rst_data", out_data, 0);
    expq.delete();
    @(negedge clk);
    reset = 1'b1;
    #1 mon_en = 1'b1;
    d0 = done_cnt;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      check("no_resume", out_valid | busy | done, 0);
    end
    check("no_done_after_reset", done_cnt - d0, 0);

    rmode = 2;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < NR; i++) regs[i] = $urandom;
      repeat ($urandom_range(0, 3)) @(posedge clk);
      run_dump(1'b0, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
